mmips_net_if: RTL and testbench
===============================

// Module: mmips_net_if
// PURPOSE
//  Packet network interface directly downstream of the mMIPS memory-mapped device bridge; consumes its dev_* strobes.
//  Queues CPU-written words into a TX FIFO and serialises them as head/body/tail flits on a valid/ready link.
//  Deserialises received flits for this node into an RX FIFO that the CPU drains word by word via dev_r.
// PARAMETERS
//  NODE_ID   0  this node's address; received heads with other dest are dropped
//  DEST_W    8  destination/source field width in head flit (<=16)
//  TX_DEPTH  4  TX FIFO entries, power of two >=2
//  RX_DEPTH  4  RX FIFO entries, power of two >=2
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  dev_din       in  32   CPU write data
//  dev_wdata     in   1   latch dev_din into data holding reg (dreg)
//  dev_waddr     in   1   latch dev_din[DEST_W-1:0] into dest reg
//  dev_w         in   1   push {eop,dest,dreg} into TX FIFO
//  dev_send_eop  in   1   with dev_w: pushed word closes packet
//  dev_r         in   1   pop RX FIFO head
//  dev_dout      out 32   RX FIFO head data (first-word-fall-through), 0 when empty
//  dev_rdyr      out  1   RX FIFO non-empty
//  dev_rdyw      out  1   TX FIFO has >=1 free entry
//  dev_rcv_eop   out  1   RX head word is last of its packet (0 when empty)
//  tx_flit       out 34   {type[1:0],payload[31:0]}
//  tx_valid      out  1   flit valid; tx_ready  in 1  link accepts
//  rx_flit       in  34   received flit; rx_valid in 1; rx_ready out 1
// BEHAVIOUR
//  Reset: FIFOs empty, dreg/dest=0, TX_HEAD, RX_IDLE; dev_dout=0, dev_rdyr=0, dev_rdyw=1, dev_rcv_eop=0, tx_valid=0, rx_ready=1.
//  Flit types: 01 HEAD payload {16'b0-padded src[DEST_W], dest[DEST_W]} (dest in [DEST_W-1:0], src in [15+..]), 00 BODY, 10 TAIL, 11 reserved.
//  Push: dev_w & dev_waddr same cycle -> entry dest = dev_din[DEST_W-1:0] (bypass), else dest reg; data always dreg (pre-edge).
//  dev_w when full: dropped, no state change. dev_r when empty: ignored. Push+pop same cycle allowed at any occupancy.
//  dev_rdyw, dev_rdyr, dev_rcv_eop derive combinationally from registered counts/head; entry visible one cycle after push edge.
//  TX FSM: TX_HEAD: tx_valid=!tx_empty, HEAD flit {NODE_ID,entry.dest}; handshake -> TX_BODY (no pop).
//   TX_BODY: tx_valid=!tx_empty, type TAIL if entry.eop else BODY, payload entry.data; handshake pops; TAIL -> TX_HEAD.
//   dest of non-first entries ignored. tx_flit held stable while tx_valid & !tx_ready.
//  RX FSM: RX_IDLE: rx_ready=1; HEAD with dest==NODE_ID -> RX_DATA; other dest -> RX_DROP; BODY/TAIL/11 discarded.
//   RX_DATA: rx_ready=!rx_full; BODY pushes {0,payload}; TAIL pushes {1,payload} -> RX_IDLE; HEAD -> restart packet (new
//   HEAD re-evaluated as in RX_IDLE; already-queued words keep eop=0); type 11 discarded.
//   RX_DROP: rx_ready=1, discard until TAIL -> RX_IDLE.
//  Latency: dev_w edge N -> HEAD valid cycle N+1; rx TAIL accepted edge M -> dev_rdyr high cycle M+1 if previously empty.
//  Counts are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
//  Reset mid-packet truncates both directions; the network tolerates truncated packets.
// CONFIGURATION
//  MMIPS_NETIF_STATS_EN defined: extra outputs stat_tx_pkts[15:0] (TAIL handshakes), stat_rx_pkts[15:0] (TAILs pushed),
//   stat_rx_drop[15:0] (HEADs sent to RX_DROP); wrap at 2^16; reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared include netif_defs.vh: flit type codes, TX/RX state encodings, FLIT_W=34.
//  Sub-module mmips_netif_fifo (WIDTH, DEPTH; FWFT, async rst_n, full/empty/count), instantiated for TX and RX.
// TESTING
//  wdata 0x11, waddr 0x00020005 + dev_w + eop, tx_ready=1 -> HEAD {NODE_ID,0x05} then TAIL 0x11, back to TX_HEAD.
//  5 dev_w with tx_ready=0, TX_DEPTH=4 -> dev_rdyw=0 after 4th, 5th dropped; release -> HEAD,B,B,B(with eop on 4th=TAIL only if set).
//  RX HEAD dest=NODE_ID, BODY 0xA, TAIL 0xB -> dev_rdyr=1, dev_dout=0xA eop=0; dev_r -> 0xB eop=1; dev_r -> dev_rdyr=0.
//  RX HEAD dest!=NODE_ID, BODY, TAIL -> nothing queued, rx_ready stays 1, stat_rx_drop=1 (stats build).
//  RX FIFO full during RX_DATA -> rx_ready=0 until dev_r pops; no flit lost; simultaneous push+pop keeps count.
//  rst_n low mid-TX_BODY -> tx_valid=0 immediately, FIFOs empty, dev_rdyw=1, next packet starts with HEAD.

Source files
------------

// File: rtl/mmips_net_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmips_net_if_pkg
// Brief    : Shared definitions for the mMIPS network interface: flit width,
//            flit type codes, TX/RX state encodings and head payload builder.
// Revision : 1.0 - initial release
// ============================================================================
package mmips_net_if_pkg;

  localparam int FLIT_W = 34;
  localparam int WORD_W = 32;

  // Flit type codes carried in tx_flit/rx_flit[33:32]
  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_e;

  // Transmit serialiser states
  typedef enum logic [0:0] {
    TX_HEAD = 1'b0,
    TX_BODY = 1'b1
  } tx_state_e;

  // Receive deserialiser states
  typedef enum logic [1:0] {
    RX_IDLE = 2'b00,
    RX_DATA = 2'b01,
    RX_DROP = 2'b10
  } rx_state_e;

  // Head payload: source address in the upper half, destination in the lower
  function automatic logic [WORD_W-1:0] head_payload(input logic [15:0] src,
                                                     input logic [15:0] dst);
    return {src, dst};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmips_netif_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mmips_netif_fifo
// Brief    : First-word-fall-through FIFO with full/empty/count. A push into a
//            full FIFO is dropped unless a pop happens in the same cycle; a pop
//            of an empty FIFO is ignored. DEPTH must be a power of two >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module mmips_netif_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign dout    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_rd_en = pop & ~empty;
  assign w_wr_en = push & (~full | pop);

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmips_net_if.sv
`default_nettype none
// ============================================================================
// Module   : mmips_net_if
// Brief    : Packet network interface behind the mMIPS device bridge. CPU
//            words are queued in a TX FIFO and sent as head/body/tail flits;
//            received packets addressed to NODE_ID are queued in an RX FIFO
//            that the CPU drains through dev_r/dev_dout.
// Options  : define MMIPS_NETIF_STATS_EN to add the stat_* packet counters.
// Revision : 1.0 - initial release
// ============================================================================
module mmips_net_if
  import mmips_net_if_pkg::*;
#(
  parameter int NODE_ID  = 0,
  parameter int DEST_W   = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dev_din,
  input  logic              dev_wdata,
  input  logic              dev_waddr,
  input  logic              dev_w,
  input  logic              dev_send_eop,
  input  logic              dev_r,
  output logic [31:0]       dev_dout,
  output logic              dev_rdyr,
  output logic              dev_rdyw,
  output logic              dev_rcv_eop,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              rx_valid,
  output logic              rx_ready
`ifdef MMIPS_NETIF_STATS_EN
  ,
  output logic [15:0]       stat_tx_pkts,
  output logic [15:0]       stat_rx_pkts,
  output logic [15:0]       stat_rx_drop
`endif
);

  localparam logic [DEST_W-1:0] NODE_ADDR = DEST_W'(NODE_ID);
  localparam int TXE_W = 1 + DEST_W + WORD_W;  // {eop, dest, data}
  localparam int RXE_W = 1 + WORD_W;           // {eop, data}

  logic [WORD_W-1:0]         r_dreg;
  logic [DEST_W-1:0]         r_dest;
  tx_state_e                 r_tx_state;
  tx_state_e                 w_tx_state_nxt;
  rx_state_e                 r_rx_state;
  rx_state_e                 w_rx_state_nxt;

  logic [DEST_W-1:0]         w_push_dest;
  logic [TXE_W-1:0]          w_tx_din;
  logic [TXE_W-1:0]          w_tx_dout;
  logic                      w_tx_pop;
  logic                      w_tx_full;
  logic                      w_tx_empty;
  logic [$clog2(TX_DEPTH):0] w_tx_count;
  logic                      w_tx_eop;
  logic [DEST_W-1:0]         w_tx_head_dest;
  logic [WORD_W-1:0]         w_tx_data;
  logic                      w_tx_hs;

  logic [RXE_W-1:0]          w_rx_din;
  logic [RXE_W-1:0]          w_rx_dout;
  logic                      w_rx_push;
  logic                      w_rx_eop;
  logic                      w_rx_full;
  logic                      w_rx_empty;
  logic [$clog2(RX_DEPTH):0] w_rx_count;
  flit_type_e                w_rx_type;
  logic [WORD_W-1:0]         w_rx_pay;
  logic                      w_rx_acc;
  logic                      w_rx_hit;
  logic                      w_drop_head;
  logic                      w_unused;

  // ---------------------------------------------------------------- CPU side
  // Data holding and destination registers written by the bridge strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dreg <= '0;
      r_dest <= '0;
    end else begin
      if (dev_wdata) begin
        r_dreg <= dev_din;
      end
      if (dev_waddr) begin
        r_dest <= dev_din[DEST_W-1:0];
      end
    end
  end

  // An address written in the same cycle as the push applies to that word
  assign w_push_dest = dev_waddr ? dev_din[DEST_W-1:0] : r_dest;
  assign w_tx_din    = {dev_send_eop, w_push_dest, r_dreg};

  mmips_netif_fifo #(
    .WIDTH (TXE_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dev_w),
    .pop   (w_tx_pop),
    .din   (w_tx_din),
    .dout  (w_tx_dout),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  assign w_tx_eop       = w_tx_dout[TXE_W-1];
  assign w_tx_head_dest = w_tx_dout[WORD_W +: DEST_W];
  assign w_tx_data      = w_tx_dout[WORD_W-1:0];
  assign dev_rdyw       = ~w_tx_full;

  // ------------------------------------------------------------ TX serialiser
  assign tx_valid = ~w_tx_empty;
  assign w_tx_hs  = tx_valid & tx_ready;

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_HEAD;
    end else begin
      r_tx_state <= w_tx_state_nxt;
    end
  end

  // Head flit is generated from the first entry without popping it; body and
  // tail flits pop one entry each. Flit is a function of state and FIFO head
  // only, so it holds steady while the link stalls.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    tx_flit        = '0;
    case (r_tx_state)
      TX_HEAD: begin
        tx_flit = {FLIT_HEAD, head_payload(16'(NODE_ADDR), 16'(w_tx_head_dest))};
        if (w_tx_hs) begin
          w_tx_state_nxt = TX_BODY;
        end
      end
      TX_BODY: begin
        tx_flit = {(w_tx_eop ? FLIT_TAIL : FLIT_BODY), w_tx_data};
        if (w_tx_hs) begin
          w_tx_pop = 1'b1;
          if (w_tx_eop) begin
            w_tx_state_nxt = TX_HEAD;
          end
        end
      end
      default: begin
        w_tx_state_nxt = TX_HEAD;
      end
    endcase
  end

  // ---------------------------------------------------------- RX deserialiser
  assign w_rx_type = flit_type_e'(rx_flit[FLIT_W-1:WORD_W]);
  assign w_rx_pay  = rx_flit[WORD_W-1:0];
  assign w_rx_hit  = (w_rx_pay[DEST_W-1:0] == NODE_ADDR);
  // Only the data state can be blocked; idle and drop always sink flits
  assign rx_ready  = (r_rx_state != RX_DATA) | ~w_rx_full;
  assign w_rx_acc  = rx_valid & rx_ready;

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_state_nxt;
    end
  end

  // A head seen mid-packet restarts reception; words already queued keep
  // eop=0, so the CPU sees them merged into the following packet.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_push      = 1'b0;
    w_rx_eop       = 1'b0;
    w_drop_head    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_acc && (w_rx_type == FLIT_HEAD)) begin
          w_rx_state_nxt = w_rx_hit ? RX_DATA : RX_DROP;
          w_drop_head    = ~w_rx_hit;
        end
      end
      RX_DATA: begin
        if (w_rx_acc) begin
          case (w_rx_type)
            FLIT_BODY: begin
              w_rx_push = 1'b1;
            end
            FLIT_TAIL: begin
              w_rx_push      = 1'b1;
              w_rx_eop       = 1'b1;
              w_rx_state_nxt = RX_IDLE;
            end
            FLIT_HEAD: begin
              w_rx_state_nxt = w_rx_hit ? RX_DATA : RX_DROP;
              w_drop_head    = ~w_rx_hit;
            end
            default: begin
              w_rx_push = 1'b0;
            end
          endcase
        end
      end
      RX_DROP: begin
        if (w_rx_acc && (w_rx_type == FLIT_TAIL)) begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  assign w_rx_din = {w_rx_eop, w_rx_pay};

  mmips_netif_fifo #(
    .WIDTH (RXE_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_rx_push),
    .pop   (dev_r),
    .din   (w_rx_din),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

  assign dev_rdyr    = ~w_rx_empty;
  assign dev_dout    = w_rx_empty ? '0 : w_rx_dout[WORD_W-1:0];
  assign dev_rcv_eop = ~w_rx_empty & w_rx_dout[RXE_W-1];

  // Occupancy counts are exported by the FIFO but flags suffice here
  assign w_unused = &{1'b0, w_tx_count, w_rx_count, w_drop_head};

`ifdef MMIPS_NETIF_STATS_EN
  logic [15:0] r_stat_tx;
  logic [15:0] r_stat_rx;
  logic [15:0] r_stat_drop;

  // Free-running packet counters, wrapping at 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_tx   <= '0;
      r_stat_rx   <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_tx_pop && w_tx_eop) begin
        r_stat_tx <= r_stat_tx + 16'd1;
      end
      if (w_rx_push && w_rx_eop) begin
        r_stat_rx <= r_stat_rx + 16'd1;
      end
      if (w_drop_head) begin
        r_stat_drop <= r_stat_drop + 16'd1;
      end
    end
  end

  assign stat_tx_pkts = r_stat_tx;
  assign stat_rx_pkts = r_stat_rx;
  assign stat_rx_drop = r_stat_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmips_net_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmips_net_if
// Brief    : Self-checking bench for mmips_net_if (NODE_ID=3, depths 4).
//            Per-cycle vector table plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmips_net_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dev_din;
  logic        dev_wdata, dev_waddr, dev_w, dev_send_eop, dev_r;
  logic [31:0] dev_dout;
  logic        dev_rdyr, dev_rdyw, dev_rcv_eop;
  logic [33:0] tx_flit;
  logic        tx_valid, tx_ready;
  logic [33:0] rx_flit;
  logic        rx_valid, rx_ready;
`ifdef MMIPS_NETIF_STATS_EN
  logic [15:0] stat_tx_pkts, stat_rx_pkts, stat_rx_drop;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmips_net_if #(
    .NODE_ID  (3),
    .DEST_W   (8),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dev_din      (dev_din),
    .dev_wdata    (dev_wdata),
    .dev_waddr    (dev_waddr),
    .dev_w        (dev_w),
    .dev_send_eop (dev_send_eop),
    .dev_r        (dev_r),
    .dev_dout     (dev_dout),
    .dev_rdyr     (dev_rdyr),
    .dev_rdyw     (dev_rdyw),
    .dev_rcv_eop  (dev_rcv_eop),
    .tx_flit      (tx_flit),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_flit      (rx_flit),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
`ifdef MMIPS_NETIF_STATS_EN
    ,
    .stat_tx_pkts (stat_tx_pkts),
    .stat_rx_pkts (stat_rx_pkts),
    .stat_rx_drop (stat_rx_drop)
`endif
  );

  // ctl = {wdata, waddr, w, send_eop, r, tx_ready}
  // e_st = {rdyr, rdyw, rcv_eop, tx_valid, rx_ready}
  typedef struct {
    logic [31:0] din;
    logic [5:0]  ctl;
    logic        rxv;
    logic [33:0] rxf;
    logic [31:0] e_dout;
    logic [4:0]  e_st;
    logic [33:0] e_txf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] din, input logic [5:0] ctl,
                       input logic rxv, input logic [33:0] rxf);
    dev_din = din;
    {dev_wdata, dev_waddr, dev_w, dev_send_eop, dev_r, tx_ready} = ctl;
    rx_valid = rxv;
    rx_flit  = rxf;
  endtask

  function automatic logic [4:0] st();
    return {dev_rdyr, dev_rdyw, dev_rcv_eop, tx_valid, rx_ready};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ---------------------------------------------------------- vector table
    // TX: single-word packet with address bypass
    tbl.push_back('{32'h0,        6'b000000, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h11,       6'b100000, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h00020005, 6'b011101, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000001, 1'b0, 34'h0, 32'h0, 5'b01011, {2'b01, 32'h00030005}});
    tbl.push_back('{32'h0, 6'b000001, 1'b0, 34'h0, 32'h0, 5'b01011, {2'b10, 32'h00000011}});
    tbl.push_back('{32'h0, 6'b000001, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    // TX: two-word packet, dest from register, stall holds head, body keeps state
    tbl.push_back('{32'h22, 6'b100000, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0,  6'b001000, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b0, 34'h0, 32'h0, 5'b01011, {2'b01, 32'h00030005}});
    tbl.push_back('{32'h0, 6'b000000, 1'b0, 34'h0, 32'h0, 5'b01011, {2'b01, 32'h00030005}});
    tbl.push_back('{32'h0, 6'b000001, 1'b0, 34'h0, 32'h0, 5'b01011, {2'b01, 32'h00030005}});
    tbl.push_back('{32'h0, 6'b000001, 1'b0, 34'h0, 32'h0, 5'b01011, {2'b00, 32'h00000022}});
    tbl.push_back('{32'h0,  6'b000001, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h33, 6'b100001, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h9,  6'b011101, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000001, 1'b0, 34'h0, 32'h0, 5'b01011, {2'b10, 32'h00000033}});
    tbl.push_back('{32'h0, 6'b000001, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    // RX: packet for this node, then CPU drain
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b01, 32'h00070003}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b00, 32'h0000000A}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b10, 32'h0000000B}, 32'hA, 5'b11001, 34'h0});
    tbl.push_back('{32'h0, 6'b000010, 1'b0, 34'h0, 32'hA, 5'b11001, 34'h0});
    tbl.push_back('{32'h0, 6'b000010, 1'b0, 34'h0, 32'hB, 5'b11101, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    // RX: foreign packet dropped (head inside drop ignored), stray flits in idle
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b01, 32'h00000005}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b00, 32'h00000055}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b01, 32'h00000003}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b10, 32'h00000066}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b00, 32'h00000077}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b10, 32'h00000088}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});
    // RX: head mid-packet restarts, reserved type discarded
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b01, 32'h00000003}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b00, 32'h00000001}, 32'h0, 5'b01001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b01, 32'h00000003}, 32'h1, 5'b11001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b11, 32'h000000FF}, 32'h1, 5'b11001, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b1, {2'b10, 32'h00000002}, 32'h1, 5'b11001, 34'h0});
    tbl.push_back('{32'h0, 6'b000010, 1'b0, 34'h0, 32'h1, 5'b11001, 34'h0});
    tbl.push_back('{32'h0, 6'b000010, 1'b0, 34'h0, 32'h2, 5'b11101, 34'h0});
    tbl.push_back('{32'h0, 6'b000000, 1'b0, 34'h0, 32'h0, 5'b01001, 34'h0});

    // ---------------------------------------------------------------- reset
    rst_n = 1'b0;
    drive(32'h0, 6'b000000, 1'b0, 34'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].din, tbl[i].ctl, tbl[i].rxv, tbl[i].rxf);
      #1;
      chk($sformatf("v%0d status", i), 64'(st()), 64'(tbl[i].e_st));
      chk($sformatf("v%0d dev_dout", i), 64'(dev_dout), 64'(tbl[i].e_dout));
      if (tbl[i].e_st[1]) begin
        chk($sformatf("v%0d tx_flit", i), 64'(tx_flit), 64'(tbl[i].e_txf));
      end
    end

`ifdef MMIPS_NETIF_STATS_EN
    chk("stat_tx_pkts", 64'(stat_tx_pkts), 64'd2);
    chk("stat_rx_pkts", 64'(stat_rx_pkts), 64'd2);
    chk("stat_rx_drop", 64'(stat_rx_drop), 64'd1);
`endif

    // ------------------------------------------- TX FIFO fill with stalled link
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(32'hD0 + 32'(i), 6'b100000, 1'b0, 34'h0);
      @(negedge clk);
      drive(32'h42, {1'b0, (i == 0), 1'b1, (i == 3), 2'b00}, 1'b0, 34'h0);
      #1;
      chk($sformatf("fill%0d dev_rdyw", i), 64'(dev_rdyw), 64'(i < 4));
      chk($sformatf("fill%0d tx_valid", i), 64'(tx_valid), 64'(i > 0));
    end
    @(negedge clk);
    drive(32'h0, 6'b000000, 1'b0, 34'h0);
    #1;
    chk("full dev_rdyw", 64'(dev_rdyw), 64'd0);
    chk("full held head", 64'(tx_flit), 64'({2'b01, 32'h00030042}));
    begin
      logic [33:0] exp_f [5];
      exp_f[0] = {2'b01, 32'h00030042};
      exp_f[1] = {2'b00, 32'h000000D0};
      exp_f[2] = {2'b00, 32'h000000D1};
      exp_f[3] = {2'b00, 32'h000000D2};
      exp_f[4] = {2'b10, 32'h000000D3};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        drive(32'h0, 6'b000001, 1'b0, 34'h0);
        #1;
        chk($sformatf("drain%0d tx_valid", i), 64'(tx_valid), 64'd1);
        chk($sformatf("drain%0d tx_flit", i), 64'(tx_flit), 64'(exp_f[i]));
      end
    end
    @(negedge clk);
    #1;
    chk("after drain tx_valid", 64'(tx_valid), 64'd0);
    chk("after drain dev_rdyw", 64'(dev_rdyw), 64'd1);

    // ------------------------------------ RX FIFO full backpressure, push+pop
    begin
      logic [33:0] f [9];
      logic [4:0]  r_in;
      logic [4:0]  e_rdy;
      logic [31:0] e_d [9];
      f[0] = {2'b01, 32'h3};   f[1] = {2'b00, 32'h100}; f[2] = {2'b00, 32'h101};
      f[3] = {2'b00, 32'h102}; f[4] = {2'b00, 32'h103}; f[5] = {2'b00, 32'h104};
      f[6] = {2'b10, 32'h200}; f[7] = {2'b10, 32'h200}; f[8] = {2'b10, 32'h200};
      e_d[0] = 32'h0;   e_d[1] = 32'h0;   e_d[2] = 32'h100;
      e_d[3] = 32'h100; e_d[4] = 32'h100; e_d[5] = 32'h101;
      e_d[6] = 32'h101; e_d[7] = 32'h101; e_d[8] = 32'h102;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        drive(32'h0, {4'b0000, (i == 4 || i == 7), 1'b0}, 1'b1, f[i]);
        #1;
        chk($sformatf("rxfull%0d rx_ready", i), 64'(rx_ready), 64'(!(i == 6 || i == 7)));
        chk($sformatf("rxfull%0d dev_dout", i), 64'(dev_dout), 64'(e_d[i]));
      end
      @(negedge clk);
      drive(32'h0, 6'b000000, 1'b0, 34'h0);
      #1;
      chk("rxfull idle rx_ready", 64'(rx_ready), 64'd1);
      e_d[0] = 32'h102; e_d[1] = 32'h103; e_d[2] = 32'h104; e_d[3] = 32'h200;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        drive(32'h0, 6'b000010, 1'b0, 34'h0);
        #1;
        chk($sformatf("rxdrain%0d dev_dout", i), 64'(dev_dout), 64'(e_d[i]));
        chk($sformatf("rxdrain%0d eop", i), 64'(dev_rcv_eop), 64'(i == 3));
      end
      @(negedge clk);
      drive(32'h0, 6'b000000, 1'b0, 34'h0);
      #1;
      chk("rxdrain empty dev_rdyr", 64'(dev_rdyr), 64'd0);
    end

    // ------------------------------------------------ reset mid-TX_BODY / RX
    @(negedge clk);
    drive(32'h77, 6'b100000, 1'b0, 34'h0);
    @(negedge clk);
    drive(32'h13, 6'b011000, 1'b0, 34'h0);
    @(negedge clk);
    drive(32'h0, 6'b000001, 1'b1, {2'b01, 32'h3});
    #1;
    chk("rst pre head", 64'(tx_flit), 64'({2'b01, 32'h00030013}));
    @(negedge clk);
    drive(32'h0, 6'b000000, 1'b1, {2'b00, 32'hC});
    #1;
    chk("rst pre body", 64'(tx_flit), 64'({2'b00, 32'h77}));
    @(negedge clk);
    drive(32'h0, 6'b000000, 1'b0, 34'h0);
    #1;
    chk("rst pre rx dout", 64'(dev_dout), 64'h0C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst async status", 64'(st()), 64'(5'b01001));
    chk("rst async dev_dout", 64'(dev_dout), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0, 6'b001100, 1'b0, 34'h0);
    #1;
    chk("post rst idle tx_valid", 64'(tx_valid), 64'd0);
    @(negedge clk);
    drive(32'h0, 6'b000001, 1'b0, 34'h0);
    #1;
    chk("post rst head", 64'(tx_flit), 64'({2'b01, 32'h00030000}));
    @(negedge clk);
    drive(32'h0, 6'b000001, 1'b1, {2'b00, 32'hE});
    #1;
    chk("post rst tail", 64'(tx_flit), 64'({2'b10, 32'h0}));
    chk("post rst tail valid", 64'(tx_valid), 64'd1);
    @(negedge clk);
    drive(32'h0, 6'b000000, 1'b0, 34'h0);
    #1;
    chk("post rst rx discard", 64'(dev_rdyr), 64'd0);
    chk("post rst tx done", 64'(tx_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
